// File: rtl/crc16_t.sv
// Transmit-side USB DATA-phase CRC16 generator: forwards link-layer bytes to the PHY
// through one output register and appends the inverted CRC16 (low byte first).
module crc16_t #(
    parameter logic [15:0] CRC_INIT   = 16'hFFFF,
    parameter logic [15:0] CRC_POLY_R = 16'hA001
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_data_on,
    output logic       tx_sop_en,
    output logic       tx_eop_en,
    input  logic       tx_lt_sop,
    input  logic       tx_lt_eop,
    input  logic       tx_lt_valid,
    output logic       tx_lt_ready,
    input  logic [7:0] tx_lt_data,
    output logic       tx_sop,
    output logic       tx_eop,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic [7:0] tx_data
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_PAYLOAD = 3'd1;
    localparam logic [2:0] S_CRC_LO  = 3'd2;
    localparam logic [2:0] S_CRC_HI  = 3'd3;
    localparam logic [2:0] S_BYPASS  = 3'd4;

    // One byte of reflected CRC16, unrolled into combinational logic.
    function automatic logic [15:0] crc_byte(input logic [15:0] crc_in, input logic [7:0] byte_in);
        logic [15:0] r;
        r = crc_in ^ {8'h00, byte_in};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY_R) : (r >> 1);
        end
        return r;
    endfunction

    logic [2:0]  state_q, state_d;
    logic [15:0] crc_q, crc_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        sop_q, sop_d;
    logic        eop_q, eop_d;
    logic        crc_hi_q, crc_hi_d;   // current output byte is an appended CRC high byte

    logic out_free;
    logic lt_accept;
    logic is_data_pid;

    assign out_free    = ~valid_q | tx_ready;
    assign lt_accept   = tx_lt_valid & tx_lt_ready;
    assign is_data_pid = (tx_lt_data[1:0] == 2'b11);

    always_comb begin
        tx_lt_ready = 1'b0;
        case (state_q)
            S_IDLE:              tx_lt_ready = tx_data_on & out_free;
            S_PAYLOAD, S_BYPASS: tx_lt_ready = out_free;
            default:             tx_lt_ready = 1'b0;
        endcase
        tx_lt_ready = tx_lt_ready & ~rst;
    end

    assign tx_sop_en = ~rst & lt_accept & (state_q == S_IDLE) & tx_lt_sop & is_data_pid;
    assign tx_eop_en = ~rst & valid_q & tx_ready & eop_q & crc_hi_q;

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        valid_d  = valid_q & ~tx_ready;
        data_d   = data_q;
        sop_d    = sop_q;
        eop_d    = eop_q;
        crc_hi_d = crc_hi_q;
        case (state_q)
            S_IDLE: begin
                if (lt_accept && tx_lt_sop) begin
                    valid_d  = 1'b1;
                    data_d   = tx_lt_data;
                    sop_d    = 1'b1;
                    crc_hi_d = 1'b0;
                    crc_d    = CRC_INIT;
                    if (is_data_pid) begin
                        eop_d   = 1'b0;
                        state_d = tx_lt_eop ? S_CRC_LO : S_PAYLOAD;
                    end else begin
                        eop_d   = tx_lt_eop;
                        state_d = tx_lt_eop ? S_IDLE : S_BYPASS;
                    end
                end
            end
            S_PAYLOAD: begin
                if (lt_accept) begin
                    valid_d  = 1'b1;
                    data_d   = tx_lt_data;
                    sop_d    = 1'b0;
                    eop_d    = 1'b0;
                    crc_hi_d = 1'b0;
                    crc_d    = crc_byte(crc_q, tx_lt_data);
                    if (tx_lt_eop) state_d = S_CRC_LO;
                end
            end
            S_CRC_LO: begin
                if (out_free) begin
                    valid_d  = 1'b1;
                    data_d   = ~crc_q[7:0];
                    sop_d    = 1'b0;
                    eop_d    = 1'b0;
                    crc_hi_d = 1'b0;
                    state_d  = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (out_free) begin
                    valid_d  = 1'b1;
                    data_d   = ~crc_q[15:8];
                    sop_d    = 1'b0;
                    eop_d    = 1'b1;
                    crc_hi_d = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            S_BYPASS: begin
                if (lt_accept) begin
                    valid_d  = 1'b1;
                    data_d   = tx_lt_data;
                    sop_d    = 1'b0;
                    eop_d    = tx_lt_eop;
                    crc_hi_d = 1'b0;
                    if (tx_lt_eop) state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            crc_q    <= CRC_INIT;
            valid_q  <= 1'b0;
            data_q   <= 8'h00;
            sop_q    <= 1'b0;
            eop_q    <= 1'b0;
            crc_hi_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sop_q    <= sop_d;
            eop_q    <= eop_d;
            crc_hi_q <= crc_hi_d;
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = data_q;
    assign tx_sop   = sop_q;
    assign tx_eop   = eop_q;

endmodule

// File: tb/tb_crc16_t.sv
// Scoreboard bench for crc16_t: expected PHY bytes are queued as stimulus is driven
// and popped as the PHY side accepts them.
module tb_crc16_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_data_on;
    logic       tx_sop_en, tx_eop_en;
    logic       tx_lt_sop, tx_lt_eop, tx_lt_valid, tx_lt_ready;
    logic [7:0] tx_lt_data;
    logic       tx_sop, tx_eop, tx_valid, tx_ready;
    logic [7:0] tx_data;

    crc16_t dut (
        .clk(clk), .rst(rst), .tx_data_on(tx_data_on),
        .tx_sop_en(tx_sop_en), .tx_eop_en(tx_eop_en),
        .tx_lt_sop(tx_lt_sop), .tx_lt_eop(tx_lt_eop), .tx_lt_valid(tx_lt_valid),
        .tx_lt_ready(tx_lt_ready), .tx_lt_data(tx_lt_data),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .tx_data(tx_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [9:0] sb_q[$];          // {sop, eop, data}
    int         sop_en_cnt = 0;
    int         eop_en_cnt = 0;
    int         run_len = 0;
    int         last_run = 0;
    int         ready_mode = 0;   // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    logic       prev_stall = 1'b0;
    logic [9:0] prev_word = '0;

    initial begin
        int cyc = 0;
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ready_mode)
                1:       tx_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
                2:       tx_ready = ($urandom_range(0, 2) != 0);
                default: tx_ready = 1'b1;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [9:0] w;
        w = {tx_sop, tx_eop, tx_data};
        if (tx_sop_en) sop_en_cnt++;
        if (tx_eop_en) eop_en_cnt++;
        if (tx_valid) run_len++;
        else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
        end
        if (prev_stall) begin
            check("stall_valid", tx_valid, 1'b1);
            check("stall_hold", w, prev_word);
        end
        if (tx_valid && tx_ready) begin
            if (sb_q.size() == 0) check("unexpected_byte", sb_q.size(), 1);
            else check("phy_byte", w, sb_q.pop_front());
        end
        prev_stall = tx_valid & ~tx_ready;
        prev_word  = w;
    end

    function automatic logic [15:0] crc_model(input logic [7:0] bytes[$]);
        logic [15:0] c = 16'hFFFF;
        foreach (bytes[i]) begin
            for (int b = 0; b < 8; b++) begin
                logic fb;
                fb = c[0] ^ bytes[i][b];
                c  = c >> 1;
                if (fb) c = c ^ 16'hA001;
            end
        end
        return ~c;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic s, input logic e);
        sb_q.push_back({s, e, d});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
        int  n = 0;
        bit  done = 0;
        tx_lt_valid = 1'b1;
        tx_lt_data  = d;
        tx_lt_sop   = s;
        tx_lt_eop   = e;
        while (!done) begin
            @(negedge clk);
            if (tx_lt_ready) done = 1;
            else if (++n > 200) begin
                check("lt_accept_timeout", n, 0);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        tx_lt_valid = 1'b0;
        tx_lt_sop   = 1'b0;
        tx_lt_eop   = 1'b0;
    endtask

    task automatic send_packet(input logic [7:0] pid, input logic [7:0] pay[$]);
        if (pay.size() == 0) send_byte(pid, 1'b1, 1'b1);
        else begin
            send_byte(pid, 1'b1, 1'b0);
            foreach (pay[i]) send_byte(pay[i], 1'b0, i == pay.size() - 1);
        end
    endtask

    task automatic drain();
        int n = 0;
        while ((sb_q.size() != 0 || tx_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain", sb_q.size(), 0);
        repeat (4) @(posedge clk);
        #1;
    endtask

    logic [7:0] pay[$];
    logic [7:0] pay2[$];
    int         base_sop, base_eop;
    logic [15:0] c;

    initial begin
        rst = 1'b1; tx_data_on = 1'b1;
        tx_lt_valid = 1'b0; tx_lt_sop = 1'b0; tx_lt_eop = 1'b0; tx_lt_data = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", tx_valid, 1'b0);
        check("rst_outs", {tx_sop, tx_eop, tx_data, tx_sop_en, tx_eop_en}, 12'h000);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // DATA0 "123456789"
        pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        base_sop = sop_en_cnt; base_eop = eop_en_cnt;
        push_exp(8'hC3, 1, 0);
        foreach (pay[i]) push_exp(pay[i], 0, 0);
        push_exp(8'hC8, 0, 0);
        push_exp(8'hB4, 0, 1);
        send_packet(8'hC3, pay);
        drain();
        check("d0_sop_en", sop_en_cnt - base_sop, 1);
        check("d0_eop_en", eop_en_cnt - base_eop, 1);
        check("d0_contig", last_run, 12);

        // zero-length DATA1
        base_sop = sop_en_cnt; base_eop = eop_en_cnt;
        push_exp(8'h4B, 1, 0); push_exp(8'h00, 0, 0); push_exp(8'h00, 0, 1);
        pay.delete();
        send_packet(8'h4B, pay);
        drain();
        check("zl_sop_en", sop_en_cnt - base_sop, 1);
        check("zl_eop_en", eop_en_cnt - base_eop, 1);

        // single zero payload byte
        push_exp(8'hC3, 1, 0); push_exp(8'h00, 0, 0); push_exp(8'h40, 0, 0); push_exp(8'hBF, 0, 1);
        pay = {8'h00};
        send_packet(8'hC3, pay);
        drain();

        // backpressure 1,0,0,1
        ready_mode = 1;
        base_sop = sop_en_cnt; base_eop = eop_en_cnt;
        pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        push_exp(8'hC3, 1, 0);
        foreach (pay[i]) push_exp(pay[i], 0, 0);
        push_exp(8'hC8, 0, 0);
        push_exp(8'hB4, 0, 1);
        send_packet(8'hC3, pay);
        drain();
        check("bp_sop_en", sop_en_cnt - base_sop, 1);
        check("bp_eop_en", eop_en_cnt - base_eop, 1);
        ready_mode = 0;

        // ACK passthrough
        base_sop = sop_en_cnt; base_eop = eop_en_cnt;
        push_exp(8'hD2, 1, 1);
        pay.delete();
        send_packet(8'hD2, pay);
        drain();
        check("ack_sop_en", sop_en_cnt - base_sop, 0);
        check("ack_eop_en", eop_en_cnt - base_eop, 0);

        // reset mid-packet after 3 payload bytes
        base_eop = eop_en_cnt;
        push_exp(8'hC3, 1, 0); push_exp(8'h31, 0, 0); push_exp(8'h32, 0, 0); push_exp(8'h33, 0, 0);
        send_byte(8'hC3, 1, 0);
        send_byte(8'h31, 0, 0);
        send_byte(8'h32, 0, 0);
        send_byte(8'h33, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_outs", {tx_valid, tx_sop, tx_eop, tx_data}, 11'h000);
        check("mid_rst_en", {tx_sop_en, tx_eop_en}, 2'b00);
        rst = 1'b0;
        #1;
        check("post_rst_ready", tx_lt_ready, 1'b1);
        drain();
        check("mid_rst_no_crc", eop_en_cnt - base_eop, 0);

        // tx_data_on gating in IDLE
        tx_data_on  = 1'b0;
        tx_lt_valid = 1'b1; tx_lt_sop = 1'b1; tx_lt_eop = 1'b1; tx_lt_data = 8'hC3;
        repeat (3) begin
            @(negedge clk);
            check("gated_ready", tx_lt_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        tx_lt_valid = 1'b0; tx_lt_sop = 1'b0; tx_lt_eop = 1'b0;
        tx_data_on  = 1'b1;
        drain();

        // byte without sop in IDLE is dropped, then a normal packet follows
        send_byte(8'h55, 1'b0, 1'b0);
        push_exp(8'hD2, 1, 1);
        pay.delete();
        send_packet(8'hD2, pay);
        drain();

        // back-to-back random DATA packets under random backpressure
        ready_mode = 2;
        for (int k = 0; k < 4; k++) begin
            base_sop = sop_en_cnt; base_eop = eop_en_cnt;
            pay.delete(); pay2.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) pay.push_back(8'($urandom));
            for (int i = 0; i < $urandom_range(0, 5); i++) pay2.push_back(8'($urandom));
            push_exp(8'hC3, 1, 0);
            foreach (pay[i]) push_exp(pay[i], 0, 0);
            c = crc_model(pay);
            push_exp(c[7:0], 0, 0); push_exp(c[15:8], 0, 1);
            push_exp(8'h4B, 1, 0);
            foreach (pay2[i]) push_exp(pay2[i], 0, 0);
            c = crc_model(pay2);
            push_exp(c[7:0], 0, 0); push_exp(c[15:8], 0, 1);
            send_packet(8'hC3, pay);
            send_packet(8'h4B, pay2);
            drain();
            check("rnd_sop_en", sop_en_cnt - base_sop, 2);
            check("rnd_eop_en", eop_en_cnt - base_eop, 2);
        end
        ready_mode = 0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
